ahbl_slave_mem: RTL

//  AHB-Lite responder used as the slave-side counterpart in bus-functional testbenches.

---
 rtl/ahbl_slave_mem.sv | 76 +++++++
 1 files changed

// File: rtl/ahbl_slave_mem.sv
// ahbl_slave_mem: AHB-Lite SRAM responder with configurable wait states and an error window.
module ahbl_slave_mem #(
    parameter int          DEPTH    = 1024,
    parameter int          WAITS    = 0,
    parameter logic [31:0] ERR_BASE = 32'hFFFF_0000,
    parameter logic [31:0] ERR_SIZE = 32'h0000_0100
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_DATA = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;
    localparam logic [3:0] CNT_INIT = 4'(WAITS == 0 ? 0 : WAITS - 1);
    logic [2:0]    state, state_n, start;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [3:0]    lanes;
    logic          accept, in_win, bad;
    logic [31:0]   mem [DEPTH] = '{default: '0};
    logic          unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};
    assign HREADYOUT = state != S_WAIT && state != S_ERR1;
    assign HRESP     = state == S_ERR1 || state == S_ERR2;
    assign HRDATA    = (state == S_DATA && !write_q) ? mem[addr_q[AW+1:2]] : '0;
    // Only states that finish their data phase this cycle may take a new address phase.
    assign accept = HSEL && HREADYIN && HTRANS[1] && HREADYOUT;
    assign in_win = ERR_SIZE != '0 && HADDR >= ERR_BASE &&
                    {1'b0, HADDR} < {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};
    assign bad = in_win || HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) ||
                 (HSIZE == 3'd2 && HADDR[1:0] != 2'd0);
    always_comb begin
        start   = !accept ? S_IDLE : bad ? S_ERR1 : WAITS == 0 ? S_DATA : S_WAIT;
        state_n = state == S_WAIT ? (cnt == 4'd0 ? S_DATA : S_WAIT) :
                  state == S_ERR1 ? S_ERR2 : start;
        lanes   = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                  size_q == 3'd1 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == S_WAIT ? cnt - 4'd1 : accept ? CNT_INIT : cnt;
            if (accept) begin
                addr_q  <= HADDR[AW+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end
    // Write commits at the end of the completion cycle; a reset in that cycle drops it.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_DATA && write_q)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
    end
endmodule
